bt656_sync_generator: RTL and testbench

Transmit-side BT.656 timing generator for 525-line / 858-sample (1716-word) video, the counterpart of `sync_parser`. It free-runs horizontal and vertical counters and emits a 10-bit BT.656 word stream with EAV/SAV codes and protection bits. Blanking fill is inserted between lines, and caller-supplied active samples are passed through with reserved-code clipping. It sits in front of the output encoder and produces test or scrambled streams with the same framing `sync_parser` and `line_rotator` consume.

---
 rtl/bt656_sync_generator.sv | 227 ++++++++++++++++++++++
 tb/tb_bt656_sync_generator.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt656_sync_generator.sv
// -----------------------------------------------------------------------------
// bt656_sync_generator
//
// Transmit-side BT.656 timing generator for 525-line video. Free-running word
// and line counters walk the raster. Each cycle the generator registers one
// 10-bit BT.656 word:
//   - EAV and SAV codes (3FF 000 000 XY) with protection bits,
//   - horizontal blanking fill (200/040, Cb-Y-Cr-Y order),
//   - blanking fill in the active slots of vertical-blanking lines,
//   - caller samples in the active slots of picture lines, clipped so they
//     never collide with the reserved 000-003 / 3FC-3FF timing codes.
//
// Parameters
//   LINE_WORDS    words per line including EAV and SAV (default 1716)
//   ACTIVE_WORDS  active video words per line (default 1440);
//                 LINE_WORDS - ACTIVE_WORDS must be at least 10
//
// Ports
//   clk         word clock, one BT.656 word per cycle
//   reset_n     synchronous active-low reset
//   frame_sync  restart request: next counter state is line 1, word 0
//   data_in     active sample, taken in the cycle data_req is high
//   data_req    combinational, high in active slots of picture lines
//   bt_656      registered BT.656 word
//   H, V, F     registered timing flags aligned with bt_656
//   line_num    registered line number (1..525) aligned with bt_656
// -----------------------------------------------------------------------------
module bt656_sync_generator #(
  parameter int LINE_WORDS   = 1716,
  parameter int ACTIVE_WORDS = 1440
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_sync,
  input  logic [9:0] data_in,
  output logic       data_req,
  output logic [9:0] bt_656,
  output logic       H,
  output logic       V,
  output logic       F,
  output logic [9:0] line_num
);

  // ---------------------------------------------------------------------------
  // Raster geometry
  // ---------------------------------------------------------------------------
  localparam int H_BITS = $clog2(LINE_WORDS);

  localparam logic [H_BITS-1:0] H_LAST      = H_BITS'(LINE_WORDS - 1);
  localparam logic [H_BITS-1:0] BLANK_START = H_BITS'(4);
  localparam logic [H_BITS-1:0] SAV_START   = H_BITS'(LINE_WORDS - ACTIVE_WORDS - 4);
  localparam logic [H_BITS-1:0] ACT_START   = H_BITS'(LINE_WORDS - ACTIVE_WORDS);

  localparam logic [9:0] LINES_PER_FRAME = 10'd525;

  // Blanking fill words: chroma midscale and luma black
  localparam logic [9:0] BLANK_C = 10'h200;
  localparam logic [9:0] BLANK_Y = 10'h040;

  // Legal sample range; anything outside is a reserved timing code
  localparam logic [9:0] SAMPLE_MIN = 10'h004;
  localparam logic [9:0] SAMPLE_MAX = 10'h3FB;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [H_BITS-1:0] h_cnt_q, h_cnt_d;
  logic [9:0]        line_q,  line_d;

  logic [9:0]        bt_656_q,   bt_656_d;
  logic              h_q,        h_d;
  logic              v_q,        v_d;
  logic              f_q,        f_d;
  logic [9:0]        line_num_q, line_num_d;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Fourth word of a timing reference: {1, F, V, H, P3..P0, 00}
  function automatic logic [9:0] xy_word(input logic f, input logic v, input logic h);
    logic p3, p2, p1, p0;
    p3 = v ^ h;
    p2 = f ^ h;
    p1 = f ^ v;
    p0 = f ^ v ^ h;
    return {1'b1, f, v, h, p3, p2, p1, p0, 2'b00};
  endfunction

  // Word idx (0..3) of a timing reference whose last word is xy
  function automatic logic [9:0] sync_word(input logic [1:0] idx, input logic [9:0] xy);
    logic [9:0] w;
    case (idx)
      2'd0:    w = 10'h3FF;
      2'd1:    w = 10'h000;
      2'd2:    w = 10'h000;
      default: w = xy;
    endcase
    return w;
  endfunction

  // Keep user samples out of the reserved code space
  function automatic logic [9:0] clip_sample(input logic [9:0] s);
    logic [9:0] r;
    if (s < SAMPLE_MIN) begin
      r = SAMPLE_MIN;
    end else if (s > SAMPLE_MAX) begin
      r = SAMPLE_MAX;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Slot decode for the current counter position
  // ---------------------------------------------------------------------------
  logic       in_eav;
  logic       in_sav;
  logic       in_active;
  logic       in_hblank;
  logic       line_v;
  logic       line_f;
  logic [1:0] sav_idx;
  logic       hblank_odd;
  logic       active_odd;

  assign in_eav    = (h_cnt_q < BLANK_START);
  assign in_sav    = (h_cnt_q >= SAV_START) && (h_cnt_q < ACT_START);
  assign in_active = (h_cnt_q >= ACT_START);
  assign in_hblank = !in_eav && !in_sav && !in_active;

  // Position inside SAV. SAV_START need not be 4-aligned, so subtract its low
  // bits; the modulo-4 wrap of the 2-bit difference is exactly what we want.
  assign sav_idx = h_cnt_q[1:0] - SAV_START[1:0];

  // Cb/Y alternation counts from the start of each region, so the parity of
  // the offset only depends on the low bit of the region start.
  assign hblank_odd = h_cnt_q[0] ^ BLANK_START[0];
  assign active_odd = h_cnt_q[0] ^ ACT_START[0];

  // Field 1 covers lines 4-265; field 2 wraps around the frame boundary.
  assign line_f = !((line_q >= 10'd4) && (line_q <= 10'd265));
  assign line_v = (line_q <= 10'd19) ||
                  ((line_q >= 10'd264) && (line_q <= 10'd282));

  // Sample request is live only outside reset, so a caller never sees a
  // request for a slot whose output will be discarded by the reset edge.
  assign data_req = reset_n && in_active && !line_v;

  // ---------------------------------------------------------------------------
  // Counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    h_cnt_d = h_cnt_q;
    line_d  = line_q;

    if (frame_sync) begin
      // Restart wins over the normal advance, including the frame wrap
      h_cnt_d = '0;
      line_d  = 10'd1;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (line_q == LINES_PER_FRAME) begin
        line_d = 10'd1;
      end else begin
        line_d = line_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output word for the current counter position
  // ---------------------------------------------------------------------------
  always_comb begin
    bt_656_d   = BLANK_C;
    h_d        = !in_active;
    v_d        = line_v;
    f_d        = line_f;
    line_num_d = line_q;

    if (in_eav) begin
      bt_656_d = sync_word(h_cnt_q[1:0], xy_word(line_f, line_v, 1'b1));
    end else if (in_sav) begin
      bt_656_d = sync_word(sav_idx, xy_word(line_f, line_v, 1'b0));
    end else if (in_hblank) begin
      bt_656_d = hblank_odd ? BLANK_Y : BLANK_C;
    end else if (line_v) begin
      // Active slots of vertical-blanking lines carry fill, not picture
      bt_656_d = active_odd ? BLANK_Y : BLANK_C;
    end else begin
      bt_656_d = clip_sample(data_in);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_q    <= '0;
      line_q     <= 10'd1;
      bt_656_q   <= 10'h000;
      h_q        <= 1'b0;
      v_q        <= 1'b0;
      f_q        <= 1'b0;
      line_num_q <= 10'd0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      line_q     <= line_d;
      bt_656_q   <= bt_656_d;
      h_q        <= h_d;
      v_q        <= v_d;
      f_q        <= f_d;
      line_num_q <= line_num_d;
    end
  end

  assign bt_656   = bt_656_q;
  assign H        = h_q;
  assign V        = v_q;
  assign F        = f_q;
  assign line_num = line_num_q;

endmodule

// File: tb/tb_bt656_sync_generator.sv
// -----------------------------------------------------------------------------
// tb_bt656_sync_generator
//
// Two generator instances share one clock:
//   u_a  full-size 1716/1440 raster: line 1 and line 20/22 content, clipping,
//        mid-line reset and held frame_sync.
//   u_b  narrow 16/6 raster so whole frames are affordable: line 264/300
//        codes, per-cycle H/V/F/line_num model over a frame, frame wrap and
//        frame_sync at line 100 and at the end of line 525.
// The bench tracks each instance's raster position itself from the reset,
// frame_sync and clock history it drives.
// -----------------------------------------------------------------------------
module tb_bt656_sync_generator;

  localparam int LINES   = 525;
  localparam int LW_A    = 1716;
  localparam int AW_A    = 1440;
  localparam int LW_B    = 16;
  localparam int AW_B    = 6;
  localparam int FRAME_A = LINES * LW_A;
  localparam int FRAME_B = LINES * LW_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, fs_a, req_a, h_a, v_a, f_a;
  logic [9:0] din_a, bt_a, ln_a;
  logic       rst_b_n, fs_b, req_b, h_b, v_b, f_b;
  logic [9:0] din_b, bt_b, ln_b;

  bt656_sync_generator #(.LINE_WORDS(LW_A), .ACTIVE_WORDS(AW_A)) u_a (
    .clk        (clk),
    .reset_n    (rst_a_n),
    .frame_sync (fs_a),
    .data_in    (din_a),
    .data_req   (req_a),
    .bt_656     (bt_a),
    .H          (h_a),
    .V          (v_a),
    .F          (f_a),
    .line_num   (ln_a)
  );

  bt656_sync_generator #(.LINE_WORDS(LW_B), .ACTIVE_WORDS(AW_B)) u_b (
    .clk        (clk),
    .reset_n    (rst_b_n),
    .frame_sync (fs_b),
    .data_in    (din_b),
    .data_req   (req_b),
    .bt_656     (bt_b),
    .H          (h_b),
    .V          (v_b),
    .F          (f_b),
    .line_num   (ln_b)
  );

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int         dut;
    int         line;
    int         word;
    logic [9:0] din;
    logic [9:0] exp_bt;
    logic       exp_h;
    logic       exp_v;
    logic       exp_f;
    logic       exp_req;
    string      name;
  } vec_t;

  vec_t vecs[$];

  int total = 0;
  int bad   = 0;

  // Raster position (counter state) of each instance as the bench sees it
  int pos_a = 0;
  int pos_b = 0;
  int out_pos_b = 0;
  logic out_valid_b = 1'b0;
  int req_cnt_a = 0;

  // Frame monitor tallies for u_b
  logic mon_b = 1'b0;
  logic seen_b = 1'b0;
  logic prev_h_b = 1'b0;
  logic prev_f_b = 1'b0;
  int h_rise_b = 0;
  int f_tog_b = 0;
  int f_tog_bad_b = 0;
  int flag_bad_b = 0;

  task automatic add(input int dut, input int line, input int word, input logic [9:0] din,
                     input logic [9:0] bt, input logic h, input logic v, input logic f,
                     input logic req, input string name);
    vec_t e;
    e.dut = dut; e.line = line; e.word = word; e.din = din;
    e.exp_bt = bt; e.exp_h = h; e.exp_v = v; e.exp_f = f; e.exp_req = req;
    e.name = name;
    vecs.push_back(e);
  endtask

  function automatic logic [31:0] pack(input logic [9:0] bt, input logic h, input logic v,
                                       input logic f, input logic [9:0] ln);
    return {9'd0, bt, h, v, f, ln};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor_b();
    int ln, w;
    logic eh, ev, ef;
    ln = out_pos_b / LW_B + 1;
    w  = out_pos_b % LW_B;
    eh = (w < LW_B - AW_B);
    ef = !((ln >= 4) && (ln <= 265));
    ev = (ln <= 19) || ((ln >= 264) && (ln <= 282));
    if ({h_b, v_b, f_b, ln_b} !== {eh, ev, ef, 10'(ln)}) flag_bad_b++;
    if (h_b && !prev_h_b) h_rise_b++;
    if (seen_b && (f_b != prev_f_b)) begin
      f_tog_b++;
      if (f_b ? (ln != 266) : (ln != 4)) f_tog_bad_b++;
    end
    prev_h_b = h_b;
    prev_f_b = f_b;
    seen_b   = 1'b1;
  endtask

  // One clock: inputs are stable from the previous negedge, outputs are
  // sampled at the following negedge.
  task automatic tick();
    logic ra, fa, rb, fb;
    ra = rst_a_n; fa = fs_a; rb = rst_b_n; fb = fs_b;
    if (ra && req_a) req_cnt_a++;
    @(posedge clk);
    if (!ra || fa) pos_a = 0;
    else           pos_a = (pos_a + 1) % FRAME_A;
    out_valid_b = rb;
    out_pos_b   = pos_b;
    if (!rb || fb) pos_b = 0;
    else           pos_b = (pos_b + 1) % FRAME_B;
    @(negedge clk);
    if (mon_b && out_valid_b) monitor_b();
  endtask

  task automatic goto_pos(input int dut, input int line, input int word);
    int tgt;
    int guard;
    guard = 0;
    if (dut == 0) begin
      tgt = (line - 1) * LW_A + word;
      while (pos_a != tgt && guard < 2 * FRAME_A) begin tick(); guard++; end
      if (pos_a != tgt) begin
        total++; bad++;
        $display("FAIL goto_a: pos=%0d want=%0d", pos_a, tgt);
      end
    end else begin
      tgt = (line - 1) * LW_B + word;
      while (pos_b != tgt && guard < 2 * FRAME_B) begin tick(); guard++; end
      if (pos_b != tgt) begin
        total++; bad++;
        $display("FAIL goto_b: pos=%0d want=%0d", pos_b, tgt);
      end
    end
  endtask

  task automatic apply_vec(input int i);
    vec_t vec;
    vec = vecs[i];
    goto_pos(vec.dut, vec.line, vec.word);
    if (vec.dut == 0) begin
      din_a = vec.din;
      chk({vec.name, "_req"}, {31'd0, req_a}, {31'd0, vec.exp_req});
      tick();
      chk(vec.name, pack(bt_a, h_a, v_a, f_a, ln_a),
          pack(vec.exp_bt, vec.exp_h, vec.exp_v, vec.exp_f, 10'(vec.line)));
      $display("vec %-12s line=%0d word=%0d bt=0x%03h", vec.name, vec.line, vec.word, bt_a);
    end else begin
      din_b = vec.din;
      chk({vec.name, "_req"}, {31'd0, req_b}, {31'd0, vec.exp_req});
      tick();
      chk(vec.name, pack(bt_b, h_b, v_b, f_b, ln_b),
          pack(vec.exp_bt, vec.exp_h, vec.exp_v, vec.exp_f, 10'(vec.line)));
      $display("vec %-12s line=%0d word=%0d bt=0x%03h", vec.name, vec.line, vec.word, bt_b);
    end
  endtask

  initial begin
    int req_bad;
    int data_bad;

    rst_a_n = 1'b0; fs_a = 1'b0; din_a = 10'h1A0;
    rst_b_n = 1'b0; fs_b = 1'b0; din_b = 10'h1A0;

    // Full-size raster: EAV 0-3, blank 4-271, SAV 272-275, active 276-1715
    add(0,  1,    0, 10'h155, 10'h3FF, 1, 1, 1, 0, "a_l1_w0");
    add(0,  1,    1, 10'h155, 10'h000, 1, 1, 1, 0, "a_l1_w1");
    add(0,  1,    2, 10'h155, 10'h000, 1, 1, 1, 0, "a_l1_w2");
    add(0,  1,    3, 10'h155, 10'h3C4, 1, 1, 1, 0, "a_l1_eavxy");
    add(0,  1,    4, 10'h155, 10'h200, 1, 1, 1, 0, "a_l1_bl4");
    add(0,  1,    5, 10'h155, 10'h040, 1, 1, 1, 0, "a_l1_bl5");
    add(0,  1,  270, 10'h155, 10'h200, 1, 1, 1, 0, "a_l1_bl270");
    add(0,  1,  271, 10'h155, 10'h040, 1, 1, 1, 0, "a_l1_bl271");
    add(0,  1,  272, 10'h155, 10'h3FF, 1, 1, 1, 0, "a_l1_sav0");
    add(0,  1,  273, 10'h155, 10'h000, 1, 1, 1, 0, "a_l1_sav1");
    add(0,  1,  275, 10'h155, 10'h3B0, 1, 1, 1, 0, "a_l1_savxy");
    add(0,  1,  276, 10'h155, 10'h200, 0, 1, 1, 0, "a_l1_act0");
    add(0,  1,  277, 10'h155, 10'h040, 0, 1, 1, 0, "a_l1_act1");
    add(0,  1, 1715, 10'h155, 10'h040, 0, 1, 1, 0, "a_l1_last");
    add(0,  2,    0, 10'h155, 10'h3FF, 1, 1, 1, 0, "a_l2_w0");
    add(0, 22,    0, 10'h1A0, 10'h3FF, 1, 0, 0, 0, "a_l22_w0");
    add(0, 22,    3, 10'h1A0, 10'h274, 1, 0, 0, 0, "a_l22_eavxy");
    add(0, 22,    4, 10'h1A0, 10'h200, 1, 0, 0, 0, "a_l22_bl4");
    add(0, 22,    7, 10'h1A0, 10'h040, 1, 0, 0, 0, "a_l22_bl7");
    add(0, 22,  275, 10'h1A0, 10'h200, 1, 0, 0, 0, "a_l22_savxy");
    add(0, 22,  276, 10'h002, 10'h004, 0, 0, 0, 1, "a_clip_002");
    add(0, 22,  277, 10'h000, 10'h004, 0, 0, 0, 1, "a_clip_000");
    add(0, 22,  278, 10'h003, 10'h004, 0, 0, 0, 1, "a_clip_003");
    add(0, 22,  279, 10'h004, 10'h004, 0, 0, 0, 1, "a_clip_004");
    add(0, 22,  280, 10'h3FE, 10'h3FB, 0, 0, 0, 1, "a_clip_3fe");
    add(0, 22,  281, 10'h3FB, 10'h3FB, 0, 0, 0, 1, "a_clip_3fb");
    add(0, 22,  282, 10'h3FC, 10'h3FB, 0, 0, 0, 1, "a_clip_3fc");
    add(0, 22,  283, 10'h3FF, 10'h3FB, 0, 0, 0, 1, "a_clip_3ff");
    add(0, 22,  284, 10'h1A0, 10'h1A0, 0, 0, 0, 1, "a_pass_1a0");
    add(0, 22, 1715, 10'h001, 10'h004, 0, 0, 0, 1, "a_l22_last");
    add(0, 23,    0, 10'h1A0, 10'h3FF, 1, 0, 0, 0, "a_l23_w0");
    // Narrow raster: EAV 0-3, blank 4-5, SAV 6-9, active 10-15
    add(1,   4,  0, 10'h155, 10'h3FF, 1, 1, 0, 0, "b_l4_w0");
    add(1, 264,  3, 10'h155, 10'h2D8, 1, 1, 0, 0, "b_l264_eav");
    add(1, 264,  9, 10'h155, 10'h2AC, 1, 1, 0, 0, "b_l264_sav");
    add(1, 264, 10, 10'h155, 10'h200, 0, 1, 0, 0, "b_l264_act0");
    add(1, 264, 11, 10'h155, 10'h040, 0, 1, 0, 0, "b_l264_act1");
    add(1, 300,  3, 10'h155, 10'h368, 1, 0, 1, 0, "b_l300_eav");
    add(1, 300,  4, 10'h155, 10'h200, 1, 0, 1, 0, "b_l300_bl4");
    add(1, 300,  5, 10'h155, 10'h040, 1, 0, 1, 0, "b_l300_bl5");
    add(1, 300,  9, 10'h155, 10'h31C, 1, 0, 1, 0, "b_l300_sav");
    add(1, 300, 10, 10'h2AA, 10'h2AA, 0, 0, 1, 1, "b_l300_act");
    add(1, 300, 15, 10'h000, 10'h004, 0, 0, 1, 1, "b_l300_clip");
    add(1, 525, 15, 10'h3FD, 10'h3FB, 0, 0, 1, 1, "b_l525_last");

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("a_rst_out", pack(bt_a, h_a, v_a, f_a, ln_a), 32'd0);
    chk("a_rst_req", {31'd0, req_a}, 32'd0);
    chk("b_rst_out", pack(bt_b, h_b, v_b, f_b, ln_b), 32'd0);
    chk("b_rst_req", {31'd0, req_b}, 32'd0);

    // ---------------- u_a: line 1 and line 2 start ----------------
    rst_a_n = 1'b1;
    req_cnt_a = 0;
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].dut == 0 && vecs[i].line < 20) apply_vec(i);
    chk("a_l1_req_cnt", req_cnt_a, 32'd0);

    // ---------------- u_a: line 20 with constant data ----------------
    goto_pos(0, 20, 0);
    din_a = 10'h1A0;
    req_cnt_a = 0;
    req_bad = 0;
    data_bad = 0;
    for (int w = 0; w < LW_A; w++) begin
      if (req_a !== (w >= LW_A - AW_A)) req_bad++;
      tick();
      if (w == 3) chk("a_l20_eavxy", {22'd0, bt_a}, {22'd0, 10'h274});
      if (w == LW_A - AW_A - 1) chk("a_l20_savxy", {22'd0, bt_a}, {22'd0, 10'h200});
      if (w >= LW_A - AW_A && bt_a !== 10'h1A0) data_bad++;
    end
    $display("line20 req_cnt=%0d req_bad=%0d data_bad=%0d", req_cnt_a, req_bad, data_bad);
    chk("a_l20_req_cnt", req_cnt_a, 32'd1440);
    chk("a_l20_req_win", req_bad, 32'd0);
    chk("a_l20_data", data_bad, 32'd0);

    // ---------------- u_a: line 22 clipping ----------------
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].dut == 0 && vecs[i].line >= 20) apply_vec(i);

    // ---------------- u_a: reset in the middle of an active line ----------------
    goto_pos(0, 23, 800);
    chk("a_mr_req_pre", {31'd0, req_a}, 32'd1);
    rst_a_n = 1'b0;
    #1;
    chk("a_mr_req_rst", {31'd0, req_a}, 32'd0);
    tick();
    chk("a_mr_out", pack(bt_a, h_a, v_a, f_a, ln_a), 32'd0);
    rst_a_n = 1'b1;
    tick();
    chk("a_mr_rel", pack(bt_a, h_a, v_a, f_a, ln_a), pack(10'h3FF, 1, 1, 1, 10'd1));
    $display("midline reset released bt=0x%03h line=%0d", bt_a, ln_a);

    // ---------------- u_a: frame_sync held high ----------------
    goto_pos(0, 2, 700);
    fs_a = 1'b1;
    tick();
    chk("a_fs_data", pack(bt_a, h_a, v_a, f_a, ln_a), pack(10'h200, 0, 1, 1, 10'd2));
    tick();
    chk("a_fs_eav", pack(bt_a, h_a, v_a, f_a, ln_a), pack(10'h3FF, 1, 1, 1, 10'd1));
    tick();
    chk("a_fs_pin", pack(bt_a, h_a, v_a, f_a, ln_a), pack(10'h3FF, 1, 1, 1, 10'd1));
    fs_a = 1'b0;
    tick();
    chk("a_fs_pin2", pack(bt_a, h_a, v_a, f_a, ln_a), pack(10'h3FF, 1, 1, 1, 10'd1));
    tick();
    chk("a_fs_w1", pack(bt_a, h_a, v_a, f_a, ln_a), pack(10'h000, 1, 1, 1, 10'd1));
    $display("frame_sync hold released bt=0x%03h line=%0d", bt_a, ln_a);

    // ---------------- u_b: one full frame ----------------
    rst_a_n = 1'b0;
    rst_b_n = 1'b1;
    mon_b = 1'b1;
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].dut == 1) apply_vec(i);
    mon_b = 1'b0;
    $display("frame h_rise=%0d f_tog=%0d f_tog_bad=%0d flag_bad=%0d",
             h_rise_b, f_tog_b, f_tog_bad_b, flag_bad_b);
    chk("b_h_rises", h_rise_b, 32'd525);
    chk("b_f_toggles", f_tog_b, 32'd2);
    chk("b_f_tog_line", f_tog_bad_b, 32'd0);
    chk("b_flags", flag_bad_b, 32'd0);

    // Natural wrap 525 -> 1 after exactly one frame period
    tick();
    chk("b_wrap_nat", pack(bt_b, h_b, v_b, f_b, ln_b), pack(10'h3FF, 1, 1, 1, 10'd1));

    // ---------------- u_b: frame_sync pulse mid-frame ----------------
    goto_pos(1, 100, 12);
    din_b = 10'h123;
    fs_b = 1'b1;
    chk("b_fs100_req", {31'd0, req_b}, 32'd1);
    tick();
    fs_b = 1'b0;
    chk("b_fs100_data", pack(bt_b, h_b, v_b, f_b, ln_b), pack(10'h123, 0, 0, 0, 10'd100));
    tick();
    chk("b_fs100_eav", pack(bt_b, h_b, v_b, f_b, ln_b), pack(10'h3FF, 1, 1, 1, 10'd1));
    $display("frame_sync line100 bt=0x%03h line=%0d", bt_b, ln_b);

    // ---------------- u_b: frame_sync on the last word of line 525 ----------------
    goto_pos(1, 525, 15);
    fs_b = 1'b1;
    tick();
    fs_b = 1'b0;
    tick();
    chk("b_fs525_eav", pack(bt_b, h_b, v_b, f_b, ln_b), pack(10'h3FF, 1, 1, 1, 10'd1));
    tick();
    chk("b_fs525_w1", pack(bt_b, h_b, v_b, f_b, ln_b), pack(10'h000, 1, 1, 1, 10'd1));
    $display("frame_sync line525 bt=0x%03h line=%0d", bt_b, ln_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
